led_frame_scheduler: RTL and testbench

//  Sequences one full refresh of a WS2812-style LED strip. Walks pixel index 0..NUM_LEDS-1,

---
 rtl/led_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_led_frame_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_scheduler
// Description : Walks an LED strip's pixel memory once per frame, hands each
//               GRB word to the bit driver, then holds the latch gap.
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 16,
    parameter int LATCH_CYCLES = 28000,
    parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          start_in,
    input  logic          auto_in,
    output logic [AW-1:0] pix_addr_out,
    output logic          pix_rd_out,
    input  logic [23:0]   pix_data_in,
    output logic [23:0]   color_out,
    output logic          color_valid_out,
    input  logic          color_ready_in,
    output logic          busy_out,
    output logic          frame_done_out,
    output logic [15:0]   frame_count_out
);

    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [AW-1:0] c_last_idx   = AW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] c_latch_last = LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_SEND    = 3'd3,
        S_DRAIN   = 3'd4,
        S_LATCH   = 3'd5
    } state_t;

    state_t        r_state,       w_state;
    logic [AW-1:0] r_idx,         w_idx;
    logic [LW-1:0] r_latch_cnt,   w_latch_cnt;
    logic [AW-1:0] r_pix_addr,    w_pix_addr;
    logic          r_pix_rd,      w_pix_rd;
    logic [23:0]   r_color,       w_color;
    logic          r_color_valid, w_color_valid;
    logic          r_busy,        w_busy;
    logic          r_frame_done,  w_frame_done;
    logic [15:0]   r_frame_count, w_frame_count;

    always_comb begin
        w_state       = r_state;
        w_idx         = r_idx;
        w_latch_cnt   = r_latch_cnt;
        w_pix_addr    = r_pix_addr;
        w_pix_rd      = 1'b0;
        w_color       = r_color;
        w_color_valid = r_color_valid;
        w_busy        = r_busy;
        w_frame_done  = 1'b0;
        w_frame_count = r_frame_count;

        case (r_state)
            S_IDLE: begin
                // busy was left high through the frame_done cycle; drop it here
                w_busy = 1'b0;
                if (start_in || auto_in) begin
                    w_state    = S_FETCH;
                    w_idx      = '0;
                    w_pix_addr = '0;
                    w_pix_rd   = 1'b1;
                    w_busy     = 1'b1;
                end
            end
            S_FETCH: begin
                w_state = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                w_color       = pix_data_in;
                w_color_valid = 1'b1;
                w_state       = S_SEND;
            end
            S_SEND: begin
                if (r_color_valid && color_ready_in) begin
                    w_color_valid = 1'b0;
                    if (r_idx != c_last_idx) begin
                        w_idx      = r_idx + AW'(1);
                        w_pix_addr = r_idx + AW'(1);
                        w_pix_rd   = 1'b1;
                        w_state    = S_FETCH;
                    end else begin
                        w_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // ready here means the driver has finished shifting the last pixel
                if (color_ready_in) begin
                    w_state     = S_LATCH;
                    w_latch_cnt = '0;
                end
            end
            S_LATCH: begin
                if (r_latch_cnt == c_latch_last) begin
                    w_frame_done  = 1'b1;
                    w_frame_count = r_frame_count + 16'd1;
                    w_state       = S_IDLE;
                end else begin
                    w_latch_cnt = r_latch_cnt + LW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_latch_cnt   <= '0;
            r_pix_addr    <= '0;
            r_pix_rd      <= 1'b0;
            r_color       <= '0;
            r_color_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state;
            r_idx         <= w_idx;
            r_latch_cnt   <= w_latch_cnt;
            r_pix_addr    <= w_pix_addr;
            r_pix_rd      <= w_pix_rd;
            r_color       <= w_color;
            r_color_valid <= w_color_valid;
            r_busy        <= w_busy;
            r_frame_done  <= w_frame_done;
            r_frame_count <= w_frame_count;
        end
    end

    assign pix_addr_out    = r_pix_addr;
    assign pix_rd_out      = r_pix_rd;
    assign color_out       = r_color;
    assign color_valid_out = r_color_valid;
    assign busy_out        = r_busy;
    assign frame_done_out  = r_frame_done;
    assign frame_count_out = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_frame_scheduler
// Description : Self-checking bench; expected traces come from event-time
//               arithmetic over the handshake and latch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_scheduler;

    localparam int NA   = 4;
    localparam int LA   = 10;
    localparam int NB   = 1;
    localparam int LB   = 3;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, start, auto_l, ready, sel_b;
    logic [23:0] mem_a [NA];
    logic [23:0] mem_b [NB];

    logic [1:0]  addr_a;
    logic        rd_a, valid_a, busy_a, done_a;
    logic [23:0] data_a = '0;
    logic [23:0] color_a;
    logic [15:0] cnt_a;

    logic [0:0]  addr_b;
    logic        rd_b, valid_b, busy_b, done_b;
    logic [23:0] data_b = '0;
    logic [23:0] color_b;
    logic [15:0] cnt_b;

    led_frame_scheduler #(.NUM_LEDS(NA), .LATCH_CYCLES(LA)) dut_a (
        .clk_in(clk), .rst_n_in(rst_a_n),
        .start_in(start && !sel_b), .auto_in(auto_l && !sel_b),
        .pix_addr_out(addr_a), .pix_rd_out(rd_a), .pix_data_in(data_a),
        .color_out(color_a), .color_valid_out(valid_a), .color_ready_in(ready),
        .busy_out(busy_a), .frame_done_out(done_a), .frame_count_out(cnt_a)
    );

    led_frame_scheduler #(.NUM_LEDS(NB), .LATCH_CYCLES(LB)) dut_b (
        .clk_in(clk), .rst_n_in(rst_b_n),
        .start_in(start && sel_b), .auto_in(auto_l && sel_b),
        .pix_addr_out(addr_b), .pix_rd_out(rd_b), .pix_data_in(data_b),
        .color_out(color_b), .color_valid_out(valid_b), .color_ready_in(ready),
        .busy_out(busy_b), .frame_done_out(done_b), .frame_count_out(cnt_b)
    );

    // pixel memories with one-cycle read latency
    always @(posedge clk) if (rd_a) data_a <= mem_a[addr_a];
    always @(posedge clk) if (rd_b) data_b <= mem_b[0];

    logic [31:0] o_addr;
    logic        o_rd, o_valid, o_busy, o_done;
    logic [23:0] o_color;
    logic [15:0] o_cnt;
    always_comb begin
        o_addr  = sel_b ? 32'(addr_b) : 32'(addr_a);
        o_rd    = sel_b ? rd_b    : rd_a;
        o_valid = sel_b ? valid_b : valid_a;
        o_busy  = sel_b ? busy_b  : busy_a;
        o_done  = sel_b ? done_b  : done_a;
        o_color = sel_b ? color_b : color_a;
        o_cnt   = sel_b ? cnt_b   : cnt_a;
    end

    int n_cmp = 0;
    int n_mis = 0;

    bit          exp_rd    [MAXC];
    bit          exp_valid [MAXC];
    bit          exp_done  [MAXC];
    int          exp_addr  [MAXC];
    logic [23:0] exp_color [MAXC];
    bit          r_pat     [MAXC];
    bit          stray     [MAXC];
    int          pix_valid_at [8];
    int          plan_end;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix_word(input int i);
        return sel_b ? mem_b[0] : mem_a[i[1:0]];
    endfunction

    // Event times: pixel i read at R_i, valid from R_i+2, transferred at the
    // first ready edge T_i > R_i+2, next read at T_i; latch starts at the first
    // ready edge after the last transfer and frame_done lands lat edges later.
    task automatic plan(input int n, input int lat, input int mode, input int bp_pix, input int drain_low);
        int r, t;
        for (int c = 0; c < MAXC; c++) begin
            exp_rd[c] = 1'b0; exp_valid[c] = 1'b0; exp_done[c] = 1'b0;
            exp_addr[c] = 0; exp_color[c] = '0; stray[c] = 1'b0;
            r_pat[c] = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        r = 0;
        for (int i = 0; i < n; i++) begin
            exp_rd[r] = 1'b1; exp_addr[r] = i; pix_valid_at[i] = r + 2;
            if (i == bp_pix) begin
                for (int k = 3; k <= 7; k++) r_pat[r+k] = 1'b0;
                r_pat[r+8] = 1'b1;
            end
            t = r + 3;
            while (!r_pat[t]) begin
                t++;
                if (t >= MAXC - 40) r_pat[t] = 1'b1;
            end
            for (int c = r + 2; c < t; c++) begin
                exp_valid[c] = 1'b1; exp_color[c] = pix_word(i);
            end
            r = t;
        end
        for (int k = 1; k <= drain_low; k++) r_pat[r+k] = 1'b0;
        r_pat[r+drain_low+1] = 1'b1;
        plan_end = r + drain_low + 1 + lat;
        exp_done[plan_end] = 1'b1;
    endtask

    task automatic run_frame(input int n, input int lat, input int mode, input int bp_pix,
                             input int drain_low, input bit via_start, input bit auto_lvl,
                             input int auto_drop_at, input bit chain, input int n_stray,
                             input logic [15:0] cnt_base, input int abort_pix);
        logic [15:0] cnt_next;
        cnt_next = cnt_base + 16'd1;
        plan(n, lat, mode, bp_pix, drain_low);
        repeat (n_stray) stray[$urandom_range(1, plan_end)] = 1'b1;
        for (int c = 0; c <= plan_end; c++) begin
            ready  = r_pat[c];
            start  = (c == 0 && via_start) || stray[c];
            auto_l = auto_lvl && !(auto_drop_at >= 0 && c >= auto_drop_at);
            @(posedge clk);
            @(negedge clk);
            chk("rd", c, 32'(o_rd), 32'(exp_rd[c]));
            if (exp_rd[c]) chk("addr", c, o_addr, 32'(exp_addr[c]));
            chk("valid", c, 32'(o_valid), 32'(exp_valid[c]));
            if (exp_valid[c]) chk("color", c, 32'(o_color), 32'(exp_color[c]));
            chk("done", c, 32'(o_done), 32'(exp_done[c]));
            chk("busy", c, 32'(o_busy), 32'd1);
            chk("count", c, 32'(o_cnt), 32'((c < plan_end) ? cnt_base : cnt_next));
            if (abort_pix >= 0 && c == pix_valid_at[abort_pix]) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        if (!chain) begin
            auto_l = 1'b0;
            ready  = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", plan_end + 1, 32'(o_busy), 32'd0);
            chk("idle_rd", plan_end + 1, 32'(o_rd), 32'd0);
            chk("idle_valid", plan_end + 1, 32'(o_valid), 32'd0);
            chk("idle_done", plan_end + 1, 32'(o_done), 32'd0);
            chk("idle_count", plan_end + 1, 32'(o_cnt), 32'(cnt_next));
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_rd"}, 0, 32'(rd_a), 32'd0);
        chk({tag, "_addr"}, 0, 32'(addr_a), 32'd0);
        chk({tag, "_valid"}, 0, 32'(valid_a), 32'd0);
        chk({tag, "_color"}, 0, 32'(color_a), 32'd0);
        chk({tag, "_busy"}, 0, 32'(busy_a), 32'd0);
        chk({tag, "_done"}, 0, 32'(done_a), 32'd0);
        chk({tag, "_count"}, 0, 32'(cnt_a), 32'd0);
    endtask

    logic [15:0] cnt_exp;

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; sel_b = 1'b0;
        start = 1'b0; auto_l = 1'b0; ready = 1'b0;
        for (int i = 0; i < NA; i++) mem_a[i] = 24'h0A0B00 + 24'(i);
        mem_b[0] = 24'h123456;
        repeat (3) @(negedge clk);
        chk_zero_a("reset_a");
        chk("reset_b_busy", 0, 32'(busy_b), 32'd0);
        chk("reset_b_count", 0, 32'(cnt_b), 32'd0);
        rst_a_n = 1'b1;
        @(negedge clk);
        cnt_exp = 16'd0;

        // plain frame, ready always high
        run_frame(NA, LA, 0, -1, 0, 1'b1, 1'b0, -1, 1'b0, 0, cnt_exp, -1);
        cnt_exp++;
        // backpressure on pixel 1
        run_frame(NA, LA, 0, 1, 0, 1'b1, 1'b0, -1, 1'b0, 0, cnt_exp, -1);
        cnt_exp++;
        // driver busy for 20 cycles after the last transfer
        run_frame(NA, LA, 0, -1, 20, 1'b1, 1'b0, -1, 1'b0, 0, cnt_exp, -1);
        cnt_exp++;
        // random pixels, random ready, stray start pulses
        repeat (3) begin
            for (int i = 0; i < NA; i++) mem_a[i] = 24'($urandom);
            run_frame(NA, LA, 1, -1, $urandom_range(0, 5), 1'b1, 1'b0, -1, 1'b0, 2, cnt_exp, -1);
            cnt_exp++;
        end
        // auto mode: three back-to-back frames, auto dropped during the third
        run_frame(NA, LA, 1, -1, $urandom_range(0, 4), 1'b0, 1'b1, -1, 1'b1, 3, cnt_exp, -1);
        cnt_exp++;
        run_frame(NA, LA, 1, -1, $urandom_range(0, 4), 1'b0, 1'b1, -1, 1'b1, 3, cnt_exp, -1);
        cnt_exp++;
        run_frame(NA, LA, 1, -1, $urandom_range(0, 4), 1'b0, 1'b1, 4, 1'b0, 3, cnt_exp, -1);
        cnt_exp++;

        // asynchronous reset while pixel 2 is waiting for acceptance
        run_frame(NA, LA, 1, -1, 0, 1'b1, 1'b0, -1, 1'b0, 0, cnt_exp, 2);
        #2 rst_a_n = 1'b0;
        #1 chk_zero_a("async_rst");
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_busy", c, 32'(busy_a), 32'd0);
            chk("post_rst_rd", c, 32'(rd_a), 32'd0);
            chk("post_rst_count", c, 32'(cnt_a), 32'd0);
        end
        cnt_exp = 16'd0;
        run_frame(NA, LA, 1, -1, 2, 1'b1, 1'b0, -1, 1'b0, 0, cnt_exp, -1);

        // single-pixel strip with the frame counter about to wrap
        sel_b   = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        force dut_b.r_frame_count = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut_b.r_frame_count;
        @(posedge clk);
        @(negedge clk);
        chk("preload_count", 0, 32'(cnt_b), 32'h0000FFFF);
        run_frame(NB, LB, 1, -1, $urandom_range(0, 3), 1'b1, 1'b0, -1, 1'b0, 0, 16'hFFFF, -1);
        mem_b[0] = 24'($urandom);
        run_frame(NB, LB, 1, -1, 1, 1'b1, 1'b0, -1, 1'b0, 0, 16'h0000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
